// File: rtl/ntru_params_pkg.sv
// Shared constants and state encoding for the NTRU-HRSS701 convolution accumulator.
package ntru_params_pkg;

    localparam int N    = 701;
    localparam int LOGQ = 13;
    localparam int DW   = 16;
    localparam int CW   = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } mac_state_t;

endpackage

// File: rtl/ntru_coef_out_reg.sv
// Single-entry valid/ready holding register for finished coefficients.
module ntru_coef_out_reg #(
    parameter int DATA_W = 13,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // A load in the same cycle as an accept replaces the drained entry, so valid stays high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            idx_d   = load_idx;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;

endmodule

// File: rtl/ntru_poly_mac_accum.sv
// Accumulates N partial products per coefficient and emits N coefficients mod q per ap_start.
module ntru_poly_mac_accum
    import ntru_params_pkg::*;
#(
    parameter int P_N    = N,
    parameter int P_LOGQ = LOGQ,
    parameter int P_DW   = DW,
    parameter int P_CW   = CW
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    input  logic [P_DW-1:0]   prod_din,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [P_LOGQ-1:0] coef_dout,
    output logic [P_CW-1:0]   coef_idx,
    output logic              coef_valid,
    input  logic              coef_ready
);

    localparam logic [P_CW-1:0] LAST = P_CW'(P_N - 1);

    mac_state_t      state_q, state_d;
    logic [P_DW-1:0] acc_q, acc_d;
    logic [P_CW-1:0] term_cnt_q, term_cnt_d;
    logic [P_CW-1:0] coef_cnt_q, coef_cnt_d;
    logic            done_q, done_d;

    logic            beat;
    logic            coef_load;
    logic [P_DW-1:0] sum;

    assign sum = acc_q + prod_din;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        term_cnt_d = term_cnt_q;
        coef_cnt_d = coef_cnt_q;
        done_d     = 1'b0;
        prod_ready = 1'b0;
        beat       = 1'b0;
        coef_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d    = ACCUM;
                    acc_d      = '0;
                    term_cnt_d = '0;
                    coef_cnt_d = '0;
                end
            end
            ACCUM: begin
                // Stall upstream while a finished coefficient is stuck in the output register.
                prod_ready = !coef_valid || coef_ready;
                beat       = prod_valid && prod_ready;
                if (beat) begin
                    if (term_cnt_q != LAST) begin
                        acc_d      = sum;
                        term_cnt_d = term_cnt_q + P_CW'(1);
                    end else begin
                        coef_load  = 1'b1;
                        acc_d      = '0;
                        term_cnt_d = '0;
                        if (coef_cnt_q == LAST) begin
                            state_d = DRAIN;
                        end else begin
                            coef_cnt_d = coef_cnt_q + P_CW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (coef_valid && coef_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            term_cnt_q <= '0;
            coef_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            term_cnt_q <= term_cnt_d;
            coef_cnt_q <= coef_cnt_d;
            done_q     <= done_d;
        end
    end

    // Masking to LOGQ bits is the reduction mod q, valid because q divides 2^DW.
    ntru_coef_out_reg #(
        .DATA_W (P_LOGQ),
        .IDX_W  (P_CW)
    ) u_out_reg (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .load      (coef_load),
        .load_data (sum[P_LOGQ-1:0]),
        .load_idx  (coef_cnt_q),
        .out_ready (coef_ready),
        .out_valid (coef_valid),
        .out_data  (coef_dout),
        .out_idx   (coef_idx)
    );

    assign ap_done = done_q;
    assign ap_idle = (state_q == IDLE);

endmodule

// File: tb/tb_ntru_poly_mac_accum.sv
// Directed bench for the convolution accumulator, run with N=4 so whole polynomials stay short.
module tb_ntru_poly_mac_accum;

    localparam int TN = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic [15:0] prod_din;
    logic        prod_valid;
    logic        prod_ready;
    logic [12:0] coef_dout;
    logic [9:0]  coef_idx;
    logic        coef_valid;
    logic        coef_ready;

    int compared   = 0;
    int mismatched = 0;

    int          cyc = 0;
    logic        beat_flag = 1'b0;
    int          beat_count;
    int          first_beat_cyc;
    int          last_beat_cyc;
    int          done_count;
    int          done_cyc;
    int          accept_cyc;
    logic [12:0] got_data [$];
    logic [9:0]  got_idx [$];

    logic [15:0] vec [16];
    int          expd [4];

    ntru_poly_mac_accum #(.P_N(TN)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .prod_din   (prod_din),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .coef_dout  (coef_dout),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready)
    );

    always #5 ap_clk = ~ap_clk;

    // Records beats, accepted coefficients and done pulses as seen at each rising edge.
    always @(posedge ap_clk) begin
        cyc++;
        beat_flag = prod_valid && prod_ready;
        if (beat_flag) begin
            if (beat_count == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beat_count++;
        end
        if (coef_valid && coef_ready) begin
            got_data.push_back(coef_dout);
            got_idx.push_back(coef_idx);
            accept_cyc = cyc;
        end
        if (ap_done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clearMonitor();
        got_data.delete();
        got_idx.delete();
        beat_count     = 0;
        first_beat_cyc = 0;
        last_beat_cyc  = 0;
        done_count     = 0;
        done_cyc       = 0;
        accept_cyc     = 0;
    endtask

    task automatic startRun();
        clearMonitor();
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
    endtask

    // Presents all 16 products in order, holding each until the block takes it.
    task automatic applyStimulus(input string tag);
        int i = 0;
        int stall = 0;
        while (i < 16 && stall < 200) begin
            prod_valid = 1'b1;
            prod_din   = vec[i];
            @(posedge ap_clk); #1;
            if (beat_flag) i++;
            else stall++;
        end
        prod_valid = 1'b0;
        prod_din   = 16'h0;
        checkOutput({tag, "_all_fed"}, i, 16);
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (done_count == 0 && n < 100) begin
            @(posedge ap_clk); #1;
            n++;
        end
        checkOutput({tag, "_done_seen"}, done_count, 1);
        @(posedge ap_clk); #1;
        checkOutput({tag, "_done_once"}, done_count, 1);
        checkOutput({tag, "_done_low"}, ap_done, 0);
        checkOutput({tag, "_idle"}, ap_idle, 1);
        checkOutput({tag, "_done_after_accept"}, done_cyc - accept_cyc, 1);
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_count"}, got_data.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_data.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, k), got_data[k], expd[k]);
                checkOutput($sformatf("%s_idx%0d", tag, k), got_idx[k], k);
            end
        end
    endtask

    initial begin
        ap_rst     = 1'b1;
        ap_start   = 1'b0;
        prod_din   = 16'h0;
        prod_valid = 1'b0;
        coef_ready = 1'b1;
        clearMonitor();
        repeat (2) @(posedge ap_clk);
        #1;
        checkOutput("rst_idle", ap_idle, 1);
        checkOutput("rst_done", ap_done, 0);
        checkOutput("rst_prod_ready", prod_ready, 0);
        checkOutput("rst_coef_valid", coef_valid, 0);
        checkOutput("rst_coef_dout", coef_dout, 0);
        checkOutput("rst_coef_idx", coef_idx, 0);
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        checkOutput("idle_no_start", ap_idle, 1);

        // Basic stream with continuous valid/ready: no bubbles expected.
        vec  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
                 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        expd = '{10, 26, 0, 8188};
        startRun();
        checkOutput("a_busy", ap_idle, 0);
        checkOutput("a_ready", prod_ready, 1);
        applyStimulus("a");
        waitDone("a");
        checkStream("a");
        checkOutput("a_beats", beat_count, 16);
        checkOutput("a_no_bubble", last_beat_cyc - first_beat_cyc, 15);

        // Backpressure: hold the first coefficient for 10 cycles.
        vec  = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd1, 16'd1, 16'd1, 16'd1,
                 16'd8191, 16'd1, 16'd0, 16'd0, 16'd4096, 16'd4096, 16'd4096, 16'd1};
        expd = '{100, 4, 0, 4097};
        coef_ready = 1'b0;
        startRun();
        fork
            applyStimulus("b");
            begin
                int n = 0;
                while (!coef_valid && n < 50) begin
                    @(posedge ap_clk); #1;
                    n++;
                end
                checkOutput("b_first_valid", coef_valid, 1);
                repeat (10) @(posedge ap_clk);
                #1;
                checkOutput("b_hold_valid", coef_valid, 1);
                checkOutput("b_hold_data", coef_dout, 100);
                checkOutput("b_hold_idx", coef_idx, 0);
                checkOutput("b_hold_stall", prod_ready, 0);
                checkOutput("b_hold_beats", beat_count, 4);
                coef_ready = 1'b1;
            end
        join
        waitDone("b");
        checkStream("b");

        // Wrap-around and negative-product cases.
        vec  = '{16'h7FFF, 16'h7FFF, 16'd2, 16'd0, 16'hE000, 16'd0, 16'd0, 16'd1,
                 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h8000, 16'd5, 16'd0};
        expd = '{0, 1, 8191, 5};
        startRun();
        applyStimulus("c");
        waitDone("c");
        checkStream("c");

        // Abort after two beats, then confirm a fresh run carries no residue.
        clearMonitor();
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start   = 1'b0;
        prod_valid = 1'b1;
        prod_din   = 16'd1000;
        repeat (2) @(posedge ap_clk);
        #1;
        prod_valid = 1'b0;
        ap_rst     = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        checkOutput("r_idle", ap_idle, 1);
        checkOutput("r_prod_ready", prod_ready, 0);
        checkOutput("r_coef_valid", coef_valid, 0);
        checkOutput("r_coef_dout", coef_dout, 0);
        checkOutput("r_coef_idx", coef_idx, 0);
        checkOutput("r_no_done", done_count, 0);
        vec  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
                 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        expd = '{10, 26, 0, 8188};
        startRun();
        applyStimulus("r");
        waitDone("r");
        checkStream("r");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
